// File: rtl/am2950_ioport.sv
// Registered bidirectional I/O port with R/S full flags and sticky overrun.
// Define AM2950_INVERT_EN for inverting output drivers (Am2951 behaviour).
module am2950_ioport #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             cer_,
  input  logic             ces_,
  input  logic             oea_,
  input  logic             oeb_,
  input  logic             clrr_,
  input  logic             clrs_,
  output logic             fr,
  output logic             fs,
  output logic             ovr
);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             fr_q, fr_d;
  logic             fs_q, fs_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] a_drv_c;
  logic [WIDTH-1:0] b_drv_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      s_q   <= '0;
      fr_q  <= 1'b0;
      fs_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      s_q   <= s_d;
      fr_q  <= fr_d;
      fs_q  <= fs_d;
      ovr_q <= ovr_d;
    end
  end

  // Load wins over clear; a reload onto a full register is an overrun unless cleared on the same edge.
  always_comb begin
    r_d   = r_q;
    s_d   = s_q;
    fr_d  = fr_q;
    fs_d  = fs_q;
    ovr_d = ovr_q;

    if (!cer_) begin
      r_d  = a;
      fr_d = 1'b1;
      if (fr_q && clrr_) ovr_d = 1'b1;
    end else if (!clrr_) begin
      fr_d = 1'b0;
    end

    if (!ces_) begin
      s_d  = b;
      fs_d = 1'b1;
      if (fs_q && clrs_) ovr_d = 1'b1;
    end else if (!clrs_) begin
      fs_d = 1'b0;
    end
  end

`ifdef AM2950_INVERT_EN
  assign a_drv_c = ~s_q;
  assign b_drv_c = ~r_q;
`else
  assign a_drv_c = s_q;
  assign b_drv_c = r_q;
`endif

  assign a   = oea_ ? {WIDTH{1'bz}} : a_drv_c;
  assign b   = oeb_ ? {WIDTH{1'bz}} : b_drv_c;
  assign fr  = fr_q;
  assign fs  = fs_q;
  assign ovr = ovr_q;

endmodule
